// File: rtl/julia_pixel_scanner.sv
// Julia pixel scanner: walks a frame in raster order and issues one
// z0/c seed beat per pixel over a valid/ready handshake. z0 is built by
// incremental add/sub at WIDTH bits (wrapping), so no multiplier is needed.
module julia_pixel_scanner #(
    parameter int WIDTH      = 20,
    parameter int FRACTIONAL = 10,
    parameter int INTEGRAL   = 10,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [X_BITS-1:0] frame_width,
    input  logic [Y_BITS-1:0] frame_height,
    input  logic [WIDTH-1:0]  z_real_start,
    input  logic [WIDTH-1:0]  z_imag_start,
    input  logic [WIDTH-1:0]  z_step,
    input  logic [WIDTH-1:0]  c_real_cfg,
    input  logic [WIDTH-1:0]  c_imag_cfg,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  z_real_out,
    output logic [WIDTH-1:0]  z_imag_out,
    output logic [WIDTH-1:0]  c_real_out,
    output logic [WIDTH-1:0]  c_imag_out,
    output logic [7:0]        iteration_out,
    output logic [X_BITS-1:0] pixel_x,
    output logic [Y_BITS-1:0] pixel_y,
    output logic              last_pixel,
    output logic              busy,
    output logic              done
);

    // Fixed-point split must account for every bit of the word.
    if (INTEGRAL + FRACTIONAL != WIDTH) begin : g_bad_split
        $error("INTEGRAL + FRACTIONAL must equal WIDTH");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [X_BITS-1:0] x_q, x_d, w_q, w_d;
    logic [Y_BITS-1:0] y_q, y_d, h_q, h_d;
    logic [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
    logic [WIDTH-1:0]  zrs_q, zrs_d, step_q, step_d;
    logic [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;

    logic x_end, y_end;
    assign x_end = (x_q == w_q - X_BITS'(1));
    assign y_end = (y_q == h_q - Y_BITS'(1));

    // Next-state: config latch on start, raster advance on each accepted beat.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        zrs_d   = zrs_q;
        step_d  = step_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d    = frame_width;
                    h_d    = frame_height;
                    zrs_d  = z_real_start;
                    step_d = z_step;
                    cr_d   = c_real_cfg;
                    ci_d   = c_imag_cfg;
                    x_d    = '0;
                    y_d    = '0;
                    zr_d   = z_real_start;
                    zi_d   = z_imag_start;
                    // Empty frame: report completion without emitting beats.
                    if (frame_width == '0 || frame_height == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (!x_end) begin
                        x_d  = x_q + X_BITS'(1);
                        zr_d = zr_q + step_q;
                    end else if (!y_end) begin
                        x_d  = '0;
                        y_d  = y_q + Y_BITS'(1);
                        zr_d = zrs_q;
                        zi_d = zi_q - step_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any scan in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            zrs_q   <= '0;
            step_q  <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            zrs_q   <= zrs_d;
            step_q  <= step_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
        end
    end

    assign out_valid     = (state_q == S_EMIT);
    assign done          = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign z_real_out    = zr_q;
    assign z_imag_out    = zi_q;
    assign c_real_out    = cr_q;
    assign c_imag_out    = ci_q;
    assign iteration_out = 8'd0;
    assign pixel_x       = x_q;
    assign pixel_y       = y_q;
    assign last_pixel    = out_valid && x_end && y_end;

endmodule
